// File: rtl/display_scanner.sv
// Multiplexed 4-digit common-anode 7-segment scanner with a per-frame digit snapshot,
// inter-digit blanking, leading-zero suppression and a synchronised colon.
module display_scanner #(
  parameter logic [15:0] SCAN_DIV = 16'd50000,
  parameter int          DIV_SIZE = 16,
  parameter logic [15:0] BLANK    = 16'd2
) (
  input  logic       inputClock,
  input  logic       reset,
  input  logic [3:0] minUnits,
  input  logic [3:0] minTens,
  input  logic [3:0] hourUnits,
  input  logic [3:0] hourTens,
  input  logic       secondsPulse,
  input  logic       blankLeadingZero,
  output logic [6:0] segments,
  output logic [3:0] digitEnable,
  output logic       colon,
  output logic       frameStart
);

  localparam logic [DIV_SIZE-1:0] LAST_COUNT  = DIV_SIZE'(SCAN_DIV - 16'd1);
  localparam logic [DIV_SIZE-1:0] BLANK_COUNT = DIV_SIZE'(BLANK);

  // Active-low segment patterns, bit order {g,f,e,d,c,b,a}; anything above 9 shows 'E'.
  function automatic logic [6:0] decode(input logic [3:0] value);
    case (value)
      4'd0:    decode = 7'h40;
      4'd1:    decode = 7'h79;
      4'd2:    decode = 7'h24;
      4'd3:    decode = 7'h30;
      4'd4:    decode = 7'h19;
      4'd5:    decode = 7'h12;
      4'd6:    decode = 7'h02;
      4'd7:    decode = 7'h78;
      4'd8:    decode = 7'h00;
      4'd9:    decode = 7'h10;
      default: decode = 7'h06;
    endcase
  endfunction

  logic [DIV_SIZE-1:0] prescaler, prescaler_next;
  logic [1:0]          index, index_next;
  logic [15:0]         digit_s1, digit_s2, digit_s3;
  logic [15:0]         shadow, shadow_next;
  logic                sec_s1, sec_s2;
  logic                pending, pending_next;
  logic                wrap, frame_wrap, suppress;
  logic [3:0]          digit;
  logic [3:0]          enable_next;
  logic [6:0]          segments_next;

  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
    enable_next   = 4'hF;
    segments_next = 7'h7F;
    shadow_next   = shadow;
    pending_next  = pending;

    wrap           = (prescaler == LAST_COUNT);
    prescaler_next = wrap ? '0 : prescaler + 1'b1;
    index_next     = wrap ? index + 2'd1 : index;
    frame_wrap     = wrap && (index == 2'd3);

    // Accept a snapshot only when two consecutive synchronised samples agree.
    if (pending && (digit_s2 == digit_s3)) begin
      shadow_next  = digit_s2;
      pending_next = 1'b0;
    end
    if (frame_wrap) pending_next = 1'b1;

    digit    = shadow_next[{index_next, 2'b00} +: 4];
    suppress = blankLeadingZero && (index_next == 2'd3) && (shadow_next[15:12] == 4'd0);

    if (!(prescaler_next < BLANK_COUNT) && !suppress) begin
      enable_next   = ~(4'b0001 << index_next);
      segments_next = decode(digit);
    end
  end

  always_ff @(posedge inputClock or posedge reset) begin
    if (reset) begin
      prescaler   <= '0;
      index       <= 2'd0;
      // NOTE: synchroniser stages are reset too, so the first stability check after reset is deterministic.
      digit_s1    <= 16'h0000;
      digit_s2    <= 16'h0000;
      digit_s3    <= 16'h0000;
      sec_s1      <= 1'b0;
      sec_s2      <= 1'b0;
      shadow      <= 16'h0000;
      pending     <= 1'b1;
      segments    <= 7'h7F;
      digitEnable <= 4'hF;
      colon       <= 1'b1;
      frameStart  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      prescaler   <= prescaler_next;
      index       <= index_next;
      digit_s1    <= {hourTens, hourUnits, minTens, minUnits};
      digit_s2    <= digit_s1;
      digit_s3    <= digit_s2;
      sec_s1      <= secondsPulse;
      sec_s2      <= sec_s1;
      shadow      <= shadow_next;
      pending     <= pending_next;
      segments    <= segments_next;
      digitEnable <= enable_next;
      colon       <= ~sec_s2;
      frameStart  <= frame_wrap;
    end
  end

endmodule
